// File: rtl/ether_tx_arbiter_pkg.sv
// Shared types and constants for the RMII transmit arbiter and its transmitter.
package ether_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_HDR = 3'd1,
        DATA     = 3'd2,
        DRAIN    = 3'd3,
        PAD      = 3'd4,
        COMPLETE = 3'd5,
        HOLD     = 3'd6
    } arb_state_t;

    localparam int DEF_MIN_DIBITS  = 184;
    localparam int DEF_MAX_DIBITS  = 6000;
    localparam int DEF_HOLD_CYCLES = 48;

    // 7 preamble bytes + SFD, and the 14-byte MAC header, in RMII dibits
    localparam int PREAMBLE_DIBITS = 32;
    localparam int HEADER_DIBITS   = 56;

endpackage

// File: rtl/ether_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    int cand_s;

    // Scan the rotation once, keeping the first hit
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        cand_s = 0;
        for (int k = 1; k <= N; k++) begin
            cand_s = (int'(ptr) + k) % N;
            if (!valid && req[cand_s]) begin
                valid = 1'b1;
                idx   = IW'(cand_s);
            end else begin
                valid = valid;
            end
        end
        if (valid) begin
            onehot[idx] = 1'b1;
        end else begin
            onehot = '0;
        end
    end

endmodule

// File: rtl/ether_tx_arbiter.sv
// Frame-level round-robin scheduler for the shared RMII transmit path:
// grant, payload forwarding with zero-pad/truncate, then FCS + gap hold-off.
module ether_tx_arbiter
    import ether_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int MIN_DIBITS  = DEF_MIN_DIBITS,
    parameter int MAX_DIBITS  = DEF_MAX_DIBITS,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     src_req,
    input  logic [NUM_REQ-1:0]     src_axiiv,
    input  logic [2*NUM_REQ-1:0]   src_axiid,
    input  logic [NUM_REQ-1:0]     src_last,
    output logic [NUM_REQ-1:0]     src_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   tx_preamble,
    input  logic                   tx_send_data,
    output logic                   tx_axiiv,
    output logic [1:0]             tx_axiid,
    output logic                   tx_data_complete,
    output logic                   err_underrun,
    output logic                   err_oversize
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DW = $clog2(MAX_DIBITS + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    arb_state_t         state_r, state_s;
    logic [NUM_REQ-1:0] grant_r, grant_s;
    logic [PW-1:0]      rr_ptr_r, rr_ptr_s;
    logic [DW-1:0]      dcnt_r, dcnt_s;
    logic [HW-1:0]      hcnt_r, hcnt_s;
    logic               started_r, started_s;
    logic               tx_preamble_r, tx_preamble_s;
    logic               tx_axiiv_r, tx_axiiv_s;
    logic [1:0]         tx_axiid_r, tx_axiid_s;
    logic               tx_data_complete_r, tx_data_complete_s;
    logic               err_underrun_r, err_underrun_s;
    logic               err_oversize_r, err_oversize_s;

    logic               pick_valid_s;
    logic [PW-1:0]      pick_idx_s;
    logic [NUM_REQ-1:0] pick_onehot_s;
    logic               g_valid_s, g_last_s;
    logic [1:0]         g_data_s;
    logic [NUM_REQ-1:0] src_ready_s;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req    (src_req),
        .ptr    (rr_ptr_r),
        .valid  (pick_valid_s),
        .idx    (pick_idx_s),
        .onehot (pick_onehot_s)
    );

    assign g_valid_s = |(src_axiiv & grant_r);
    assign g_last_s  = |(src_last & grant_r);

    // Mux the granted source's dibit
    always_comb begin
        g_data_s = 2'b00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_r[i]) begin
                g_data_s = src_axiid[2*i +: 2];
            end else begin
                g_data_s = g_data_s;
            end
        end
    end

    // Handshake back to the sources; must be same-cycle to consume the dibit
    always_comb begin
        src_ready_s = '0;
        case (state_r)
            DATA:    src_ready_s = src_axiiv & grant_r;
            DRAIN:   src_ready_s = grant_r;
            default: src_ready_s = '0;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_s            = state_r;
        grant_s            = grant_r;
        rr_ptr_s           = rr_ptr_r;
        dcnt_s             = dcnt_r;
        hcnt_s             = hcnt_r;
        started_s          = started_r;
        tx_preamble_s      = 1'b0;
        tx_axiiv_s         = 1'b0;
        tx_axiid_s         = 2'b00;
        tx_data_complete_s = 1'b0;
        err_underrun_s     = 1'b0;
        err_oversize_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    grant_s       = pick_onehot_s;
                    rr_ptr_s      = pick_idx_s;
                    tx_preamble_s = 1'b1;
                    dcnt_s        = '0;
                    started_s     = 1'b0;
                    state_s       = WAIT_HDR;
                end else begin
                    grant_s = '0;
                end
            end
            WAIT_HDR: begin
                if (tx_send_data) begin
                    state_s = DATA;
                end else begin
                    state_s = WAIT_HDR;
                end
            end
            DATA: begin
                if (g_valid_s) begin
                    tx_axiiv_s = 1'b1;
                    tx_axiid_s = g_data_s;
                    dcnt_s     = dcnt_r + DW'(1);
                    started_s  = 1'b1;
                    if (g_last_s) begin
                        if (dcnt_r + DW'(1) < DW'(MIN_DIBITS)) begin
                            state_s = PAD;
                        end else begin
                            state_s = COMPLETE;
                        end
                    end else if (dcnt_r + DW'(1) == DW'(MAX_DIBITS)) begin
                        err_oversize_s = 1'b1;
                        state_s        = DRAIN;
                    end else begin
                        state_s = DATA;
                    end
                end else if (started_r) begin
                    // starved mid-payload: close the frame short, no padding
                    err_underrun_s = 1'b1;
                    state_s        = COMPLETE;
                end else begin
                    state_s = DATA;
                end
            end
            DRAIN: begin
                if (g_valid_s && g_last_s) begin
                    state_s = COMPLETE;
                end else begin
                    state_s = DRAIN;
                end
            end
            PAD: begin
                tx_axiiv_s = 1'b1;
                dcnt_s     = dcnt_r + DW'(1);
                if (dcnt_r + DW'(1) >= DW'(MIN_DIBITS)) begin
                    state_s = COMPLETE;
                end else begin
                    state_s = PAD;
                end
            end
            COMPLETE: begin
                tx_data_complete_s = 1'b1;
                grant_s            = '0;
                hcnt_s             = HW'(HOLD_CYCLES);
                state_s            = HOLD;
            end
            HOLD: begin
                if (hcnt_r <= HW'(1)) begin
                    hcnt_s  = '0;
                    state_s = IDLE;
                end else begin
                    hcnt_s = hcnt_r - HW'(1);
                end
            end
            default: begin
                grant_s = '0;
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r            <= IDLE;
            grant_r            <= '0;
            rr_ptr_r           <= PW'(NUM_REQ - 1);
            dcnt_r             <= '0;
            hcnt_r             <= '0;
            started_r          <= 1'b0;
            tx_preamble_r      <= 1'b0;
            tx_axiiv_r         <= 1'b0;
            tx_axiid_r         <= 2'b00;
            tx_data_complete_r <= 1'b0;
            err_underrun_r     <= 1'b0;
            err_oversize_r     <= 1'b0;
        end else begin
            state_r            <= state_s;
            grant_r            <= grant_s;
            rr_ptr_r           <= rr_ptr_s;
            dcnt_r             <= dcnt_s;
            hcnt_r             <= hcnt_s;
            started_r          <= started_s;
            tx_preamble_r      <= tx_preamble_s;
            tx_axiiv_r         <= tx_axiiv_s;
            tx_axiid_r         <= tx_axiid_s;
            tx_data_complete_r <= tx_data_complete_s;
            err_underrun_r     <= err_underrun_s;
            err_oversize_r     <= err_oversize_s;
        end
    end

    assign src_ready        = src_ready_s;
    assign grant            = grant_r;
    assign tx_preamble      = tx_preamble_r;
    assign tx_axiiv         = tx_axiiv_r;
    assign tx_axiid         = tx_axiid_r;
    assign tx_data_complete = tx_data_complete_r;
    assign err_underrun     = err_underrun_r;
    assign err_oversize     = err_oversize_r;

endmodule

// File: tb/tb_ether_tx_arbiter.sv
// Directed self-checking bench for ether_tx_arbiter (two sources, default sizes).
module tb_ether_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] src_req, src_axiiv, src_last, src_ready, grant;
    logic [3:0] src_axiid;
    logic       tx_preamble, tx_send_data, tx_axiiv;
    logic [1:0] tx_axiid;
    logic       tx_data_complete, err_underrun, err_oversize;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ether_tx_arbiter #(.NUM_REQ(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .src_req          (src_req),
        .src_axiiv        (src_axiiv),
        .src_axiid        (src_axiid),
        .src_last         (src_last),
        .src_ready        (src_ready),
        .grant            (grant),
        .tx_preamble      (tx_preamble),
        .tx_send_data     (tx_send_data),
        .tx_axiiv         (tx_axiiv),
        .tx_axiid         (tx_axiid),
        .tx_data_complete (tx_data_complete),
        .err_underrun     (err_underrun),
        .err_oversize     (err_oversize)
    );

    // per-frame observations
    logic [1:0] got[$];
    int         nu, no, drained, pre_cnt, pre_cyc, comp_cyc, u_cyc;
    int         early_grant, bad_ready, foreign_ready;
    logic [1:0] grant_at_pre, grant_at_comp;
    logic       axiiv_before_comp;
    bit         done;

    function automatic logic [1:0] pat(input int s, input int k);
        logic [31:0] t;
        t = k * 7 + (k >> 4) + s * 3;
        return t[1:0];
    endfunction

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // The idle source keeps offering dibits so any leak of src_ready shows up.
    task automatic drive(input int s, input int n, input int lim, input int idx);
        src_axiiv = 2'b11;
        src_last  = 2'b00;
        src_axiid = 4'b0000;
        src_axiiv[s] = (idx < lim);
        if (idx < lim) begin
            src_axiid[2*s +: 2] = pat(s, idx);
            src_last[s]         = (idx == n - 1);
        end
    endtask

    task automatic run_frame(input string tag, input int s, input int n, input int cut, input int hdr_wait);
        int   idx, lim;
        bit   ov_seen, consumed, pre_seen;
        logic prev_axiiv;
        lim = (cut < 0) ? n : cut;
        idx = 0;
        got.delete();
        nu = 0; no = 0; drained = 0; pre_cnt = 0; early_grant = 0;
        bad_ready = 0; foreign_ready = 0;
        done = 0; pre_seen = 0; ov_seen = 0; prev_axiiv = 1'b0;
        tx_send_data = (hdr_wait < 0);
        drive(s, n, lim, idx);
        for (int c = 0; c < 20000 && !done; c++) begin
            @(negedge clk);
            if (!pre_seen && !tx_preamble && grant != 2'b00) early_grant++;
            if (tx_preamble) begin
                pre_cnt++;
                if (!pre_seen) begin
                    pre_seen     = 1;
                    pre_cyc      = cyc;
                    grant_at_pre = grant;
                end
            end
            if (tx_axiiv) got.push_back(tx_axiid);
            if (err_underrun) begin nu++; u_cyc = cyc; end
            if (err_oversize) begin no++; ov_seen = 1; end
            if (ov_seen && src_ready[s] && src_axiiv[s]) drained++;
            if (pre_seen && !tx_send_data && src_ready != 2'b00) bad_ready++;
            if ((src_ready & ~grant) != 2'b00) foreign_ready++;
            if (tx_data_complete) begin
                done              = 1;
                comp_cyc          = cyc;
                grant_at_comp     = grant;
                axiiv_before_comp = prev_axiiv;
            end
            prev_axiiv = tx_axiiv;
            consumed   = src_ready[s] && src_axiiv[s];
            @(posedge clk);
            #1;
            if (consumed) idx++;
            if (hdr_wait >= 0) tx_send_data = pre_seen && (cyc - pre_cyc >= hdr_wait);
            drive(s, n, lim, idx);
        end
        check_value({tag, "_done"}, done, 1);
        check_value({tag, "_foreign_ready"}, foreign_ready, 0);
    endtask

    initial begin
        int         errs, t4c, quiet;
        int         pa[3];
        logic [1:0] ga[3];
        logic [1:0] e;
        bit         hit;

        rst = 1'b1; src_req = 2'b00; src_axiiv = 2'b11; src_axiid = 4'b0000;
        src_last = 2'b00; tx_send_data = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("reset_outputs", {grant, src_ready, tx_preamble, tx_axiiv, tx_axiid,
                                      tx_data_complete, err_underrun, err_oversize}, 0);
        rst = 1'b0;
        @(negedge clk);
        check_value("idle_quiet", {grant, src_ready, tx_preamble}, 0);

        // 200 dibits from source 0, transmitter header takes a few cycles
        src_req = 2'b01;
        run_frame("t1", 0, 200, -1, 3);
        src_req = 2'b00;
        check_value("t1_grant", grant_at_pre, 2'b01);
        check_value("t1_preambles", pre_cnt, 1);
        check_value("t1_len", got.size(), 200);
        errs = 0;
        foreach (got[k]) if (got[k] !== pat(0, k)) errs++;
        check_value("t1_data_errs", errs, 0);
        check_value("t1_errflags", nu + no, 0);
        check_value("t1_complete_adjacent", axiiv_before_comp, 1);
        check_value("t1_grant_cleared", grant_at_comp, 2'b00);
        check_value("t1_wait_hdr_ready", bad_ready, 0);

        // short payload from source 1 gets zero-padded to 184
        src_req = 2'b10;
        run_frame("t2", 1, 10, -1, -1);
        src_req = 2'b00;
        check_value("t2_grant", grant_at_pre, 2'b10);
        check_value("t2_len", got.size(), 184);
        errs = 0;
        foreach (got[k]) begin
            e = (k < 10) ? pat(1, k) : 2'b00;
            if (got[k] !== e) errs++;
        end
        check_value("t2_data_errs", errs, 0);
        check_value("t2_complete_adjacent", axiiv_before_comp, 1);
        check_value("t2_hold_grant", early_grant, 0);

        // both request: rotation 0,1,0 with minimum spacing payload+51
        src_req = 2'b11;
        errs = 0;
        for (int f = 0; f < 3; f++) begin
            run_frame("t3", (f == 1) ? 1 : 0, 190, -1, -1);
            pa[f] = pre_cyc;
            ga[f] = grant_at_pre;
            errs += early_grant;
        end
        src_req = 2'b00;
        check_value("t3_grant0", ga[0], 2'b01);
        check_value("t3_grant1", ga[1], 2'b10);
        check_value("t3_grant2", ga[2], 2'b01);
        check_value("t3_spacing01", pa[1] - pa[0], 241);
        check_value("t3_spacing12", pa[2] - pa[1], 241);
        check_value("t3_hold_grant", errs, 0);

        // source 0 starves after 50 dibits
        src_req = 2'b01;
        run_frame("t4", 0, 100, 50, -1);
        src_req = 2'b10;
        t4c = comp_cyc;
        check_value("t4_len", got.size(), 50);
        errs = 0;
        foreach (got[k]) if (got[k] !== pat(0, k)) errs++;
        check_value("t4_data_errs", errs, 0);
        check_value("t4_underruns", nu, 1);
        check_value("t4_complete_after_err", comp_cyc - u_cyc, 1);

        // oversize from source 1, requested while the arbiter is still holding
        run_frame("t5", 1, 6010, -1, -1);
        src_req = 2'b00;
        check_value("t5_hold_gap", pre_cyc - t4c, 49);
        check_value("t5_hold_grant", early_grant, 0);
        check_value("t5_grant", grant_at_pre, 2'b10);
        check_value("t5_len", got.size(), 6000);
        errs = 0;
        foreach (got[k]) if (got[k] !== pat(1, k)) errs++;
        check_value("t5_data_errs", errs, 0);
        check_value("t5_oversize", no, 1);
        check_value("t5_drained", drained, 10);
        check_value("t5_underruns", nu, 0);
        quiet = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx_data_complete || tx_preamble || tx_axiiv) quiet++;
        end
        check_value("t5_quiet_after", quiet, 0);

        // asynchronous reset in the middle of a source-0 payload
        src_req = 2'b01;
        tx_send_data = 1'b1;
        drive(0, 1000, 1000, 0);
        hit = 0;
        for (int c = 0; c < 400 && !hit; c++) begin
            @(negedge clk);
            if (tx_axiiv) hit = 1;
        end
        check_value("t6_reached_data", hit, 1);
        #2;
        rst = 1'b1;
        #1;
        check_value("t6_async_reset", {grant, src_ready, tx_preamble, tx_axiiv, tx_axiid,
                                       tx_data_complete, err_underrun, err_oversize}, 0);
        @(negedge clk);
        rst = 1'b0;
        src_req = 2'b11;
        run_frame("t6", 0, 190, -1, -1);
        src_req = 2'b00;
        check_value("t6_grant_after_reset", grant_at_pre, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
